// File: rtl/cnn_conv_sequencer.sv
// rtl/cnn_conv_sequencer.sv - weight-load, start/abort and enable sequencing for the CNN convolution core
// Optional: CNN_SEQ_PERF_CNT_EN adds perf_cycles, counting CONV and ABORT cycles of the last run.
module cnn_conv_sequencer #(
   parameter int IMAGE_WIDTH  = 32,
   parameter int IMAGE_HEIGHT = 32,
   parameter int KERNEL_SIZE  = 3,
   parameter int STRIDE       = 1,
   parameter int NUM_FEATURES = 10,
   parameter int ADDR_W       = $clog2(NUM_FEATURES) + 1
) (
   input  logic                                 clk,
   input  logic                                 rst_ctrl,
   input  logic                                 load_valid,
   output logic                                 load_ready,
   input  logic [ADDR_W-1:0]                    load_feature,
   input  logic [2*KERNEL_SIZE*KERNEL_SIZE-1:0] load_weights,
   input  logic                                 clear_weights,
   input  logic                                 start,
   input  logic                                 abort,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 err,
   output logic [NUM_FEATURES-1:0]              loaded_mask,
   output logic [ADDR_W-1:0]                    feature_writeAddr,
   output logic                                 feature_WrEn,
   output logic [2*KERNEL_SIZE*KERNEL_SIZE-1:0] weights_input,
   output logic                                 rst_weights,
   output logic                                 rst_cnn,
   output logic                                 convolution_enable
`ifdef CNN_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]                          perf_cycles
`endif
);

   localparam int OW    = (IMAGE_WIDTH - KERNEL_SIZE) / STRIDE + 1;
   localparam int OH    = (IMAGE_HEIGHT - KERNEL_SIZE) / STRIDE + 1;
   localparam int N     = OW * OH;
   localparam int CNT_W = $clog2(N + 1);

   localparam logic [CNT_W-1:0]        LAST_PIX = CNT_W'(N - 1);
   localparam logic [ADDR_W-1:0]       NF_ADDR  = ADDR_W'(NUM_FEATURES);
   localparam logic [NUM_FEATURES-1:0] ONE_BIT  = NUM_FEATURES'(1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WCLR,
      CLEAR,
      CONV,
      ABORT,
      DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] counter;

   // Main sequencer: every output is registered and computed for the state being entered.
   always_ff @(posedge clk) begin
      if (!rst_ctrl) begin
         state              <= IDLE;
         counter            <= '0;
         loaded_mask        <= '0;
         done               <= 1'b0;
         err                <= 1'b0;
         busy               <= 1'b0;
         load_ready         <= 1'b1;
         feature_WrEn       <= 1'b1;
         rst_weights        <= 1'b1;
         rst_cnn            <= 1'b0;
         convolution_enable <= 1'b1;
         feature_writeAddr  <= '0;
         weights_input      <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               rst_cnn <= 1'b1;
               if (clear_weights) begin
                  rst_weights <= 1'b0;
                  busy        <= 1'b1;
                  load_ready  <= 1'b0;
                  state       <= WCLR;
               end else if (load_valid && load_ready) begin
                  if (load_feature < NF_ADDR) begin
                     feature_writeAddr <= load_feature;
                     weights_input     <= load_weights;
                     feature_WrEn      <= 1'b0;
                     load_ready        <= 1'b0;
                     state             <= LOAD;
                  end else begin
                     err <= 1'b1;
                  end
               end else if (start) begin
                  if (&loaded_mask) begin
                     rst_cnn    <= 1'b0;
                     counter    <= '0;
                     busy       <= 1'b1;
                     load_ready <= 1'b0;
                     state      <= CLEAR;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            LOAD: begin
               feature_WrEn <= 1'b1;
               loaded_mask  <= loaded_mask | (ONE_BIT << feature_writeAddr);
               load_ready   <= 1'b1;
               state        <= IDLE;
            end
            WCLR: begin
               rst_weights <= 1'b1;
               loaded_mask <= '0;
               busy        <= 1'b0;
               load_ready  <= 1'b1;
               state       <= IDLE;
            end
            CLEAR: begin
               rst_cnn            <= 1'b1;
               convolution_enable <= 1'b0;
               counter            <= '0;
               state              <= CONV;
            end
            CONV: begin
               if (abort) begin
                  convolution_enable <= 1'b1;
                  rst_cnn            <= 1'b0;
                  state              <= ABORT;
               end else if (counter == LAST_PIX) begin
                  convolution_enable <= 1'b1;
                  done               <= 1'b1;
                  state              <= DONE;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            ABORT: begin
               rst_cnn    <= 1'b1;
               busy       <= 1'b0;
               load_ready <= 1'b1;
               state      <= IDLE;
            end
            DONE: begin
               busy       <= 1'b0;
               load_ready <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef CNN_SEQ_PERF_CNT_EN
   // Run-length counter: zeroed on CLEAR, saturating count of CONV and ABORT cycles, held otherwise.
   always_ff @(posedge clk) begin
      if (!rst_ctrl) begin
         perf_cycles <= '0;
      end else if (state == CLEAR) begin
         perf_cycles <= '0;
      end else if ((state == CONV || state == ABORT) && perf_cycles != 32'hFFFF_FFFF) begin
         perf_cycles <= perf_cycles + 32'd1;
      end
   end
`endif

endmodule
